// File: rtl/ula_arbiter.sv
// ula_arbiter: two-requester round-robin front end that time-shares one
// combinational ULA. The winner's operands are registered onto the ULA, and
// the result is captured into that requester's result registers with a
// one-cycle done pulse.
module ula_arbiter #(
  parameter int unsigned WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] A0,
  input  logic [WIDTH-1:0] B0,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] B1,
  input  logic             mode0,
  input  logic             mode1,
  input  logic [2:0]       oper0,
  input  logic [2:0]       oper1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] O0,
  output logic [WIDTH-1:0] O1,
  output logic             overflow0,
  output logic             overflow1,
  output logic             zero0,
  output logic             zero1,
  output logic             ula_reset,
  output logic [WIDTH-1:0] ula_A,
  output logic [WIDTH-1:0] ula_B,
  output logic             ula_mode,
  output logic [2:0]       ula_oper,
  input  logic [WIDTH-1:0] ula_O,
  input  logic             ula_overflow,
  output logic             busy,
  output logic             grant,
  output logic [7:0]       op_count
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned OPER_W = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state,   w_state_nxt;
  logic                r_grant,   w_grant_nxt;
  logic                r_done0,   w_done0_nxt;
  logic                r_done1,   w_done1_nxt;
  logic [WIDTH-1:0]    r_O0,      w_O0_nxt;
  logic [WIDTH-1:0]    r_O1,      w_O1_nxt;
  logic                r_ovf0,    w_ovf0_nxt;
  logic                r_ovf1,    w_ovf1_nxt;
  logic                r_zero0,   w_zero0_nxt;
  logic                r_zero1,   w_zero1_nxt;
  logic [WIDTH-1:0]    r_ula_A,   w_ula_A_nxt;
  logic [WIDTH-1:0]    r_ula_B,   w_ula_B_nxt;
  logic                r_ula_mode, w_ula_mode_nxt;
  logic [OPER_W-1:0]   r_ula_oper, w_ula_oper_nxt;
  logic                r_busy,    w_busy_nxt;
  logic [CNT_W-1:0]    r_op_count, w_op_count_nxt;

  logic                w_winner;
  logic                w_ovf_cap;
  logic                w_zero_cap;

  // Round-robin pick: on a tie serve the requester that was not served last
  assign w_winner   = (req0 && req1) ? ~r_grant : req1;
  // Overflow is meaningful only for arithmetic ops; zero is derived locally
  assign w_ovf_cap  = ula_overflow & ~r_ula_mode;
  assign w_zero_cap = (ula_O == '0);

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_done0_nxt    = 1'b0;
    w_done1_nxt    = 1'b0;
    w_O0_nxt       = r_O0;
    w_O1_nxt       = r_O1;
    w_ovf0_nxt     = r_ovf0;
    w_ovf1_nxt     = r_ovf1;
    w_zero0_nxt    = r_zero0;
    w_zero1_nxt    = r_zero1;
    w_ula_A_nxt    = r_ula_A;
    w_ula_B_nxt    = r_ula_B;
    w_ula_mode_nxt = r_ula_mode;
    w_ula_oper_nxt = r_ula_oper;
    w_busy_nxt     = r_busy;
    w_op_count_nxt = r_op_count;

    case (r_state)
      S_IDLE: begin
        if (req0 || req1) begin
          w_grant_nxt    = w_winner;
          w_ula_A_nxt    = w_winner ? A1    : A0;
          w_ula_B_nxt    = w_winner ? B1    : B0;
          w_ula_mode_nxt = w_winner ? mode1 : mode0;
          w_ula_oper_nxt = w_winner ? oper1 : oper0;
          w_busy_nxt     = 1'b1;
          w_state_nxt    = S_EXEC;
        end
      end
      S_EXEC: begin
        if (r_grant) begin
          w_O1_nxt    = ula_O;
          w_ovf1_nxt  = w_ovf_cap;
          w_zero1_nxt = w_zero_cap;
          w_done1_nxt = 1'b1;
        end else begin
          w_O0_nxt    = ula_O;
          w_ovf0_nxt  = w_ovf_cap;
          w_zero0_nxt = w_zero_cap;
          w_done0_nxt = 1'b1;
        end
        w_op_count_nxt = r_op_count + CNT_W'(1);
        w_state_nxt    = S_DONE;
      end
      S_DONE: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_grant    <= 1'b1;
      r_done0    <= 1'b0;
      r_done1    <= 1'b0;
      r_O0       <= '0;
      r_O1       <= '0;
      r_ovf0     <= 1'b0;
      r_ovf1     <= 1'b0;
      r_zero0    <= 1'b0;
      r_zero1    <= 1'b0;
      r_ula_A    <= '0;
      r_ula_B    <= '0;
      r_ula_mode <= 1'b0;
      r_ula_oper <= '0;
      r_busy     <= 1'b0;
      r_op_count <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_done0    <= w_done0_nxt;
      r_done1    <= w_done1_nxt;
      r_O0       <= w_O0_nxt;
      r_O1       <= w_O1_nxt;
      r_ovf0     <= w_ovf0_nxt;
      r_ovf1     <= w_ovf1_nxt;
      r_zero0    <= w_zero0_nxt;
      r_zero1    <= w_zero1_nxt;
      r_ula_A    <= w_ula_A_nxt;
      r_ula_B    <= w_ula_B_nxt;
      r_ula_mode <= w_ula_mode_nxt;
      r_ula_oper <= w_ula_oper_nxt;
      r_busy     <= w_busy_nxt;
      r_op_count <= w_op_count_nxt;
    end
  end

  assign ula_reset = ~reset_n;
  assign done0     = r_done0;
  assign done1     = r_done1;
  assign O0        = r_O0;
  assign O1        = r_O1;
  assign overflow0 = r_ovf0;
  assign overflow1 = r_ovf1;
  assign zero0     = r_zero0;
  assign zero1     = r_zero1;
  assign ula_A     = r_ula_A;
  assign ula_B     = r_ula_B;
  assign ula_mode  = r_ula_mode;
  assign ula_oper  = r_ula_oper;
  assign busy      = r_busy;
  assign grant     = r_grant;
  assign op_count  = r_op_count;

endmodule

// File: tb/tb_ula_arbiter.sv
// Testbench for ula_arbiter: a behavioural ULA drives ula_O/ula_overflow,
// directed scenarios plus a randomized run against an operation-level model.
module tb_ula_arbiter;

  localparam int unsigned W = 6;
  localparam logic [W:0] ONE = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n, req0, req1, mode0, mode1;
  logic [W-1:0] A0, B0, A1, B1;
  logic [2:0]   oper0, oper1;
  logic         done0, done1, overflow0, overflow1, zero0, zero1;
  logic [W-1:0] O0, O1, ula_A, ula_B, ula_O;
  logic         ula_reset, ula_mode, ula_overflow, busy, grant;
  logic [2:0]   ula_oper;
  logic [7:0]   op_count;

  int total = 0;
  int bad   = 0;

  ula_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .req0(req0), .req1(req1),
    .A0(A0), .B0(B0), .A1(A1), .B1(B1),
    .mode0(mode0), .mode1(mode1), .oper0(oper0), .oper1(oper1),
    .done0(done0), .done1(done1), .O0(O0), .O1(O1),
    .overflow0(overflow0), .overflow1(overflow1), .zero0(zero0), .zero1(zero1),
    .ula_reset(ula_reset), .ula_A(ula_A), .ula_B(ula_B),
    .ula_mode(ula_mode), .ula_oper(ula_oper),
    .ula_O(ula_O), .ula_overflow(ula_overflow),
    .busy(busy), .grant(grant), .op_count(op_count)
  );

  // Behavioural ULA: {carry/borrow, result}; logic ops report a stale-high overflow
  function automatic logic [W:0] ula_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic m, input logic [2:0] op);
    logic [W:0] r;
    if (!m) begin
      case (op)
        3'b001:  r = {1'b0, a} - {1'b0, b};
        3'b010:  r = {1'b0, a} + ONE;
        3'b011:  r = {1'b0, a} - ONE;
        default: r = {1'b0, a} + {1'b0, b};
      endcase
    end else begin
      case (op)
        3'b000:  r = {1'b1, a & b};
        3'b001:  r = {1'b1, a | b};
        3'b010:  r = {1'b1, ~(a & b)};
        3'b011:  r = {1'b1, ~(a | b)};
        3'b100:  r = {1'b1, a ^ b};
        3'b101:  r = {1'b1, ~(a ^ b)};
        3'b110:  r = {1'b1, ~a};
        default: r = {1'b1, a};
      endcase
    end
    return r;
  endfunction

  assign {ula_overflow, ula_O} = ula_fn(ula_A, ula_B, ula_mode, ula_oper);

  // Expected captured {zero, overflow, O} for one operation
  function automatic logic [W+1:0] exp_res(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic m, input logic [2:0] op);
    logic [W:0]   r;
    logic [W-1:0] o;
    r = ula_fn(a, b, m, op);
    o = r[W-1:0];
    return {(o == '0), (m ? 1'b0 : r[W]), o};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [W*4+15+8-1:0] got;
    reset_n = 1'b0; req0 = 1'b1; req1 = 1'b1;
    A0 = '0; B0 = '0; A1 = '0; B1 = '0;
    mode0 = 1'b0; mode1 = 1'b0; oper0 = '0; oper1 = '0;
    tick();
    tick();
    got = {done0, done1, O0, O1, overflow0, overflow1, zero0, zero1,
           ula_A, ula_B, ula_mode, ula_oper, busy, op_count};
    total++;
    if (got !== '0) begin bad++; $display("FAIL reset_clear: got %0h exp 0", got); end
    total++;
    if (grant !== 1'b1) begin bad++; $display("FAIL reset_grant: got %b exp 1", grant); end
    total++;
    if (ula_reset !== 1'b1) begin bad++; $display("FAIL reset_ula_reset: got %b exp 1", ula_reset); end
    req0 = 1'b0; req1 = 1'b0;
    reset_n = 1'b1;
    #1;
    total++;
    if (ula_reset !== 1'b0) begin bad++; $display("FAIL release_ula_reset: got %b exp 0", ula_reset); end
    tick();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b exp 0", busy); end
  endtask

  task automatic test_single_op();
    A0 = 6'd20; B0 = 6'd30; mode0 = 1'b0; oper0 = 3'b000; req0 = 1'b1;
    tick();
    total++;
    if ({busy, grant, ula_A, ula_B, done0} !== {1'b1, 1'b0, 6'd20, 6'd30, 1'b0}) begin
      bad++; $display("FAIL single_grant: got %0h exp %0h",
                      {busy, grant, ula_A, ula_B, done0}, {1'b1, 1'b0, 6'd20, 6'd30, 1'b0});
    end
    tick();
    total++;
    if ({done0, O0, overflow0, zero0} !== {1'b1, 6'd50, 1'b0, 1'b0}) begin
      bad++; $display("FAIL single_result: got %0h exp %0h",
                      {done0, O0, overflow0, zero0}, {1'b1, 6'd50, 1'b0, 1'b0});
    end
    total++;
    if (op_count !== 8'd1) begin bad++; $display("FAIL single_count: got %0d exp 1", op_count); end
    total++;
    if ({done1, O1} !== '0) begin bad++; $display("FAIL single_other: got %0h exp 0", {done1, O1}); end
    req0 = 1'b0;
    tick();
    total++;
    if ({done0, busy} !== 2'b00) begin bad++; $display("FAIL single_after: got %b exp 00", {done0, busy}); end
  endtask

  task automatic test_overflow_zero();
    A1 = 6'd63; B1 = 6'd1; mode1 = 1'b0; oper1 = 3'b000; req1 = 1'b1;
    tick();
    total++;
    if (grant !== 1'b1) begin bad++; $display("FAIL ovf_grant: got %b exp 1", grant); end
    tick();
    total++;
    if ({done1, O1, overflow1, zero1} !== {1'b1, 6'd0, 1'b1, 1'b1}) begin
      bad++; $display("FAIL ovf_result: got %0h exp %0h",
                      {done1, O1, overflow1, zero1}, {1'b1, 6'd0, 1'b1, 1'b1});
    end
    total++;
    if ({done0, O0} !== {1'b0, 6'd50}) begin
      bad++; $display("FAIL ovf_other_held: got %0h exp %0h", {done0, O0}, {1'b0, 6'd50});
    end
    req1 = 1'b0;
    tick();
  endtask

  task automatic test_logic_op();
    A0 = 6'h2A; B0 = 6'h2A; mode0 = 1'b1; oper0 = 3'b100; req0 = 1'b1;
    tick();
    tick();
    total++;
    if ({done0, O0, overflow0, zero0, op_count} !== {1'b1, 6'd0, 1'b0, 1'b1, 8'd3}) begin
      bad++; $display("FAIL logic_xor: got %0h exp %0h",
                      {done0, O0, overflow0, zero0, op_count}, {1'b1, 6'd0, 1'b0, 1'b1, 8'd3});
    end
    req0 = 1'b0;
    tick();
  endtask

  task automatic test_arbitration();
    logic eg;
    do_reset();
    A0 = 6'd5;  B0 = 6'd7; mode0 = 1'b0; oper0 = 3'b000;
    A1 = 6'd10; B1 = 6'd3; mode1 = 1'b0; oper1 = 3'b001;
    req0 = 1'b1; req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      eg = 1'(k & 1);
      tick();
      total++;
      if ({grant, busy} !== {eg, 1'b1}) begin
        bad++; $display("FAIL arb_grant%0d: got %b exp %b", k, {grant, busy}, {eg, 1'b1});
      end
      tick();
      total++;
      if ({done1, done0} !== {eg, ~eg}) begin
        bad++; $display("FAIL arb_done%0d: got %b exp %b", k, {done1, done0}, {eg, ~eg});
      end
      total++;
      if ((eg ? O1 : O0) !== (eg ? 6'd7 : 6'd12)) begin
        bad++; $display("FAIL arb_result%0d: got %0d exp %0d", k, (eg ? O1 : O0), (eg ? 6'd7 : 6'd12));
      end
      tick();
    end
    req0 = 1'b0;
    tick();
    total++;
    if ({grant, busy} !== 2'b11) begin bad++; $display("FAIL arb_repeat1: got %b exp 11", {grant, busy}); end
    tick();
    req1 = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    A0 = 6'd9; B0 = 6'd4; mode0 = 1'b0; oper0 = 3'b000; req0 = 1'b1;
    tick();
    tick();
    req0 = 1'b0;
    tick();
    total++;
    if ({O0, op_count} !== {6'd13, 8'd1}) begin
      bad++; $display("FAIL midrst_pre: got %0h exp %0h", {O0, op_count}, {6'd13, 8'd1});
    end
    A0 = 6'd1; B0 = 6'd2; req0 = 1'b1;
    tick();
    reset_n = 1'b0;
    #1;
    total++;
    if (ula_reset !== 1'b1) begin bad++; $display("FAIL midrst_ula_reset: got %b exp 1", ula_reset); end
    tick();
    total++;
    if ({done0, O0, overflow0, zero0, op_count, busy, grant} !== {1'b0, 6'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1}) begin
      bad++; $display("FAIL midrst_clear: got %0h exp %0h",
                      {done0, O0, overflow0, zero0, op_count, busy, grant},
                      {1'b0, 6'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1});
    end
    reset_n = 1'b1;
    req0 = 1'b0;
    tick();
    total++;
    if ({done0, busy} !== 2'b00) begin bad++; $display("FAIL midrst_nodone: got %b exp 00", {done0, busy}); end
  endtask

  task automatic test_counter_wrap();
    logic [W+1:0] e;
    do_reset();
    req0 = 1'b1;
    for (int i = 0; i < 256; i++) begin
      A0 = W'($urandom); B0 = W'($urandom); mode0 = 1'($urandom); oper0 = 3'($urandom);
      e = exp_res(A0, B0, mode0, oper0);
      tick();
      tick();
      total++;
      if ({done0, zero0, overflow0, O0, op_count} !== {1'b1, e, 8'(i + 1)}) begin
        bad++; $display("FAIL wrap_op%0d: got %0h exp %0h", i,
                        {done0, zero0, overflow0, O0, op_count}, {1'b1, e, 8'(i + 1)});
      end
      tick();
    end
    req0 = 1'b0;
    total++;
    if (op_count !== 8'd0) begin bad++; $display("FAIL wrap_final: got %0d exp 0", op_count); end
  endtask

  task automatic test_random();
    int           m_cnt;
    logic         m_g;
    logic [W-1:0] sA, sB, e_O0, e_O1;
    logic         sM, e_d0, e_d1, e_v0, e_v1, e_z0, e_z1, e_busy, e_grant;
    logic [2:0]   sOp;
    logic [7:0]   e_cnt;
    logic [W+1:0] r;
    logic [63:0]  got, exp;
    do_reset();
    m_cnt = 0; m_g = 1'b1;
    sA = '0; sB = '0; sM = 1'b0; sOp = '0;
    e_O0 = '0; e_O1 = '0; e_d0 = 0; e_d1 = 0; e_v0 = 0; e_v1 = 0; e_z0 = 0; e_z1 = 0;
    e_busy = 0; e_grant = 1'b1; e_cnt = '0;
    for (int c = 0; c < 600; c++) begin
      // Requester behaviour: drop in done cycle, randomly post, scramble in flight
      if (e_d0) req0 = 1'b0;
      else if (!req0 && $urandom_range(0, 1) == 1) begin
        req0 = 1'b1; A0 = W'($urandom); B0 = W'($urandom); mode0 = 1'($urandom); oper0 = 3'($urandom);
      end else if (req0 && m_cnt != 0 && m_g == 1'b0) begin
        A0 = W'($urandom); B0 = W'($urandom); mode0 = 1'($urandom); oper0 = 3'($urandom);
      end
      if (e_d1) req1 = 1'b0;
      else if (!req1 && $urandom_range(0, 2) == 1) begin
        req1 = 1'b1; A1 = W'($urandom); B1 = W'($urandom); mode1 = 1'($urandom); oper1 = 3'($urandom);
      end else if (req1 && m_cnt != 0 && m_g == 1'b1) begin
        A1 = W'($urandom); B1 = W'($urandom); mode1 = 1'($urandom); oper1 = 3'($urandom);
      end
      // Operation-level model: one op occupies grant + capture + done-cycle
      e_d0 = 1'b0; e_d1 = 1'b0;
      if (m_cnt == 0) begin
        if (req0 || req1) begin
          m_g = (req0 && req1) ? ~e_grant : req1;
          e_grant = m_g;
          sA = m_g ? A1 : A0; sB = m_g ? B1 : B0;
          sM = m_g ? mode1 : mode0; sOp = m_g ? oper1 : oper0;
          e_busy = 1'b1;
          m_cnt = 2;
        end
      end else if (m_cnt == 2) begin
        r = exp_res(sA, sB, sM, sOp);
        if (m_g) begin {e_z1, e_v1, e_O1} = r; e_d1 = 1'b1; end
        else     begin {e_z0, e_v0, e_O0} = r; e_d0 = 1'b1; end
        e_cnt = e_cnt + 8'd1;
        m_cnt = 1;
      end else begin
        e_busy = 1'b0;
        m_cnt = 0;
      end
      tick();
      got = 64'({done0, done1, O0, O1, overflow0, overflow1, zero0, zero1, busy, grant,
                 op_count, ula_A, ula_B, ula_mode, ula_oper});
      exp = 64'({e_d0, e_d1, e_O0, e_O1, e_v0, e_v1, e_z0, e_z1, e_busy, e_grant,
                 e_cnt, sA, sB, sM, sOp});
      total++;
      if (got !== exp) begin bad++; $display("FAIL random_c%0d: got %0h exp %0h", c, got, exp); end
    end
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_overflow_zero();
    test_logic_op();
    test_arbitration();
    test_reset_mid_op();
    test_counter_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ula_arbiter.md
Name: ula_arbiter

Overview:
- Two-requester round-robin scheduler that time-shares one combinational ULA instance (6-bit ALU, 4-bit {mode, oper} opcode).
- Each requester posts operands and an opcode with a level request. The arbiter registers the winner's inputs onto the ULA, captures O/overflow/zero into that requester's result registers, and pulses done.
- Sits between the ULA and its clients.

Parameters:
- WIDTH, 6, operand/result width; must match the ULA data width.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  synchronous, active-low reset
- req0, req1  input  1 each  level request; held until the matching done pulse
- A0, B0, A1, B1  input  WIDTH each  requester operands
- mode0, mode1  input  1 each  ULA mode (0 arithmetic, 1 logic)
- oper0, oper1  input  3 each  ULA operation select
- done0, done1  output  1 each  one-cycle completion pulse
- O0, O1  output  WIDTH each  captured result
- overflow0, overflow1  output  1 each  captured overflow
- zero0, zero1  output  1 each  captured zero flag
- ula_reset  output  1  drives ULA reset
- ula_A, ula_B  output  WIDTH each  registered ULA operands
- ula_mode  output  1  registered ULA mode
- ula_oper  output  3  registered ULA oper
- ula_O  input  WIDTH  ULA result
- ula_overflow  input  1  ULA overflow
- busy  output  1  high in EXEC or DONE
- grant  output  1  index of the current/last served requester
- op_count  output  8  total completed operations

Behaviour:
- Reset: all outputs are registered. When reset_n=0 at a clock edge:
  - state=IDLE; done*, O*, overflow*, zero*, ula_A/B/mode/oper, busy, op_count all cleared to 0.
  - grant=1 (last-served pointer), so requester 0 wins the first tie.
- ula_reset = ~reset_n (combinational). It is the only non-registered output.
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - No request: stay in IDLE; ula_* hold their last values.
  - Exactly one request: grant it.
  - Both requests: grant the requester that is not equal to grant (round robin).
  - On grant: register grant, and load ula_A/B/mode/oper from the winner; go to EXEC; busy=1.
- EXEC:
  - ULA inputs are stable for the whole cycle. At the edge, capture into the granted requester's registers only:
    - O_g = ula_O
    - overflow_g = ula_overflow when ula_mode=0, else forced 0
    - zero_g = (ula_O == 0), computed locally from ula_O, not taken from the ULA.
  - Assert done_g; op_count += 1 (wraps 255->0); go to DONE.
- DONE:
  - done_g is high for exactly this cycle; requests are ignored.
  - Go to IDLE; done returns to 0; busy=0.
- Latency: req sampled at edge N -> done high during cycle N+2 -> results valid from N+2 onward and held until that requester's next completion.
- Throughput: one operation per 3 cycles. The requester must drop req in its done cycle; a req still high in IDLE starts a new operation.
- Non-granted requester: its req stays pending; its outputs are unchanged.
- Requester inputs are sampled only at the IDLE grant edge; changes afterwards do not affect the operation in flight.
- Reset during EXEC or DONE: the operation is aborted, no done pulse, results cleared per the reset list.
- Width: O*, ula_A/B are WIDTH bits; the carry/borrow appears only through ula_overflow.

Test Plan:
- Single op: reset, then req0 with A0=20, B0=30, mode0=0, oper0=000 -> done0 2 cycles later; O0=50, overflow0=0, zero0=0, op_count=1; O1/done1 stay 0.
- Overflow and zero: req1 with A1=63, B1=1, {mode,oper}=0000 -> O1=0, overflow1=1, zero1=1.
- Logic op: req0 with A0=B0=6'h2A, mode0=1, oper0=100 (XOR) -> O0=0, zero0=1, overflow0=0 even if ula_overflow is stale high.
- Arbitration: both reqs held high continuously after reset -> grant order 0,1,0,1; done pulses 3 cycles apart; each O matches its own operands; single req1 after serving 1 -> req1 granted again.
- Reset mid-op: reset_n=0 in the EXEC cycle -> next edge state=IDLE, no done pulse, O*/flags=0, op_count=0, ula_reset=1 while reset_n=0.
- Counter wrap: 256 back-to-back req0 operations -> op_count reads 255 then 0; final result correct.
